// File: rtl/clk_rst_pkg.sv
// Shared types and constants for the SoC clock/reset generator.
// Domain indices map each gated clock domain onto its source PLL.
package clk_rst_pkg;

    localparam int unsigned LOCK_CYCLES_DEFAULT = 64;
    localparam int unsigned NUM_PLLS    = 3;
    localparam int unsigned NUM_DOMAINS = 5;

    localparam int unsigned PLL_E_CORE = 0;
    localparam int unsigned PLL_P_CORE = 1;
    localparam int unsigned PLL_SL     = 2;

    localparam int unsigned DOM_E_CORE = 0;
    localparam int unsigned DOM_P_CORE = 1;
    localparam int unsigned DOM_CL     = 2;
    localparam int unsigned DOM_SL     = 3;
    localparam int unsigned DOM_PL     = 4;

    typedef struct packed {
        logic [3:0]  ref_div;
        logic [11:0] fb_div;
    } pll_cfg_t;

    typedef enum logic [1:0] {
        UNLOCKED,
        COUNTING,
        LOCKED
    } pll_state_e;

    // cl shares the p_core PLL; sl and pl share the sl PLL.
    function automatic logic [1:0] dom_src_pll(input int unsigned d);
        case (d)
            DOM_E_CORE:     return 2'(PLL_E_CORE);
            DOM_P_CORE,
            DOM_CL:         return 2'(PLL_P_CORE);
            default:        return 2'(PLL_SL);
        endcase
    endfunction

endpackage

// File: rtl/clk_rst_pll_model.sv
// Behavioural PLL lock model: registers the divider config and declares lock
// after LOCK_CYCLES ref edges of a valid, unchanged configuration.
module clk_rst_pll_model
    import clk_rst_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEFAULT
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  pll_cfg_t i_cfg,
    output logic     o_locked
);

    localparam int unsigned CW = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(LOCK_CYCLES - 1);

    pll_cfg_t   r_cfg;
    pll_state_e r_state;
    logic [CW-1:0] r_cnt;

    pll_state_e    w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic          w_cfg_changed;
    logic          w_cfg_valid;

    assign w_cfg_changed = (i_cfg != r_cfg);
    assign w_cfg_valid   = (i_cfg.ref_div != '0) && (i_cfg.fb_div != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cfg   <= '0;
            r_state <= UNLOCKED;
            r_cnt   <= '0;
        end else begin
            r_cfg   <= i_cfg;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // A config change outranks a terminal count landing on the same edge.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (w_cfg_changed || !w_cfg_valid) begin
            w_state_next = UNLOCKED;
            w_cnt_next   = '0;
        end else if (r_state != LOCKED) begin
            w_cnt_next   = r_cnt + 1'b1;
            w_state_next = (w_cnt_next == LAST) ? LOCKED : COUNTING;
        end
    end

    assign o_locked = (r_state == LOCKED);

endmodule

// File: rtl/clk_rst_generator.sv
// SoC clock/reset generator: three PLL lock models, five glitch-free gated
// domain clocks with per-domain reset synchronisers; RTC tick enabled by CLK_RST_RTC_EN.
module clk_rst_generator
    import clk_rst_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES     = LOCK_CYCLES_DEFAULT,
    parameter int unsigned RST_SYNC_STAGES = 2,
    parameter int unsigned RTC_DIV         = 16
) (
    input  logic        ref_clk_i,
    input  logic        glob_arst_i,
    output logic        rtc_o,

    input  logic [3:0]  pll_ref_div_e_core_i,
    input  logic [11:0] pll_fb_div_e_core_i,
    output logic        pll_locked_e_core_o,
    input  logic [3:0]  pll_ref_div_p_core_i,
    input  logic [11:0] pll_fb_div_p_core_i,
    output logic        pll_locked_p_core_o,
    input  logic [3:0]  pll_ref_div_sl_i,
    input  logic [11:0] pll_fb_div_sl_i,
    output logic        pll_locked_sl_o,

    input  logic        clk_en_e_core_i,
    input  logic        clk_en_p_core_i,
    input  logic        clk_en_cl_i,
    input  logic        clk_en_sl_i,
    input  logic        clk_en_pl_i,

    input  logic        arst_e_core_ni,
    input  logic        arst_p_core_ni,
    input  logic        arst_cl_ni,
    input  logic        arst_sl_ni,
    input  logic        arst_pl_ni,

    output logic        clk_e_core_o,
    output logic        clk_p_core_o,
    output logic        clk_cl_o,
    output logic        clk_sl_o,
    output logic        clk_pl_o,

    output logic        arst_e_core_no,
    output logic        arst_p_core_no,
    output logic        arst_cl_no,
    output logic        arst_sl_no,
    output logic        arst_pl_no,

    output logic        clk_src_cl_o
);

    if (RST_SYNC_STAGES < 2) begin : g_chk_sync
        $error("RST_SYNC_STAGES must be at least 2");
    end
    if ((RTC_DIV < 2) || ((RTC_DIV % 2) != 0)) begin : g_chk_rtc
        $error("RTC_DIV must be even and at least 2");
    end

    pll_cfg_t                w_pll_cfg [NUM_PLLS];
    logic [NUM_PLLS-1:0]     w_pll_locked;
    logic [NUM_DOMAINS-1:0]  w_clk_en;
    logic [NUM_DOMAINS-1:0]  w_arst_req_n;
    logic [NUM_DOMAINS-1:0]  w_clk_gated;
    logic [NUM_DOMAINS-1:0]  w_arst_out_n;

    assign w_pll_cfg[PLL_E_CORE] = '{ref_div: pll_ref_div_e_core_i, fb_div: pll_fb_div_e_core_i};
    assign w_pll_cfg[PLL_P_CORE] = '{ref_div: pll_ref_div_p_core_i, fb_div: pll_fb_div_p_core_i};
    assign w_pll_cfg[PLL_SL]     = '{ref_div: pll_ref_div_sl_i,     fb_div: pll_fb_div_sl_i};

    assign w_clk_en     = {clk_en_pl_i, clk_en_sl_i, clk_en_cl_i, clk_en_p_core_i, clk_en_e_core_i};
    assign w_arst_req_n = {arst_pl_ni, arst_sl_ni, arst_cl_ni, arst_p_core_ni, arst_e_core_ni};

    genvar gi;

    for (gi = 0; gi < NUM_PLLS; gi++) begin : g_pll
        clk_rst_pll_model #(
            .LOCK_CYCLES (LOCK_CYCLES)
        ) u_pll (
            .i_clk    (ref_clk_i),
            .i_rst    (glob_arst_i),
            .i_cfg    (w_pll_cfg[gi]),
            .o_locked (w_pll_locked[gi])
        );
    end

    // Every PLL output is ref_clk_i itself, so all gates share one source clock.
    for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
        localparam logic [1:0] SRC = dom_src_pll(gi);

        logic w_gate_en;
        logic r_gate_en;
        logic w_rst_req;
        logic [RST_SYNC_STAGES-1:0] r_rst_sync;

        assign w_gate_en = w_clk_en[gi] & w_pll_locked[SRC] & ~glob_arst_i;

        // Enable only changes while the source is low, so pulses are never cut short.
        always_latch begin
            if (!ref_clk_i) begin
                r_gate_en <= w_gate_en;
            end
        end

        assign w_clk_gated[gi] = ref_clk_i & r_gate_en;

        assign w_rst_req = glob_arst_i | ~w_arst_req_n[gi] | ~w_pll_locked[SRC];

        always_ff @(posedge ref_clk_i or posedge w_rst_req) begin
            if (w_rst_req) begin
                r_rst_sync <= '0;
            end else begin
                r_rst_sync <= {r_rst_sync[RST_SYNC_STAGES-2:0], 1'b1};
            end
        end

        assign w_arst_out_n[gi] = r_rst_sync[RST_SYNC_STAGES-1];
    end

`ifdef CLK_RST_RTC_EN
    localparam int unsigned RTC_CW = $clog2(RTC_DIV);
    localparam logic [RTC_CW-1:0] RTC_LAST = RTC_CW'(RTC_DIV - 1);

    logic [RTC_CW-1:0] r_rtc_cnt;
    logic              r_rtc;

    always_ff @(posedge ref_clk_i or posedge glob_arst_i) begin
        if (glob_arst_i) begin
            r_rtc_cnt <= '0;
            r_rtc     <= 1'b0;
        end else if (r_rtc_cnt == RTC_LAST) begin
            r_rtc_cnt <= '0;
            r_rtc     <= ~r_rtc;
        end else begin
            r_rtc_cnt <= r_rtc_cnt + 1'b1;
        end
    end

    assign rtc_o = r_rtc;
`else
    assign rtc_o = 1'b0;
`endif

    assign pll_locked_e_core_o = w_pll_locked[PLL_E_CORE];
    assign pll_locked_p_core_o = w_pll_locked[PLL_P_CORE];
    assign pll_locked_sl_o     = w_pll_locked[PLL_SL];

    assign clk_e_core_o = w_clk_gated[DOM_E_CORE];
    assign clk_p_core_o = w_clk_gated[DOM_P_CORE];
    assign clk_cl_o     = w_clk_gated[DOM_CL];
    assign clk_sl_o     = w_clk_gated[DOM_SL];
    assign clk_pl_o     = w_clk_gated[DOM_PL];

    assign arst_e_core_no = w_arst_out_n[DOM_E_CORE];
    assign arst_p_core_no = w_arst_out_n[DOM_P_CORE];
    assign arst_cl_no     = w_arst_out_n[DOM_CL];
    assign arst_sl_no     = w_arst_out_n[DOM_SL];
    assign arst_pl_no     = w_arst_out_n[DOM_PL];

    assign clk_src_cl_o = ref_clk_i;

endmodule

// File: tb/tb_clk_rst_generator.sv
// Scoreboard bench for clk_rst_generator: stimulus queues timed expectations,
// an independent monitor compares the observed output vector when each falls due.
module tb_clk_rst_generator;

    logic        ref_clk_i = 1'b0;
    logic        glob_arst_i;
    logic        rtc_o;
    logic [3:0]  pll_ref_div_e_core_i, pll_ref_div_p_core_i, pll_ref_div_sl_i;
    logic [11:0] pll_fb_div_e_core_i, pll_fb_div_p_core_i, pll_fb_div_sl_i;
    logic        pll_locked_e_core_o, pll_locked_p_core_o, pll_locked_sl_o;
    logic        clk_en_e_core_i, clk_en_p_core_i, clk_en_cl_i, clk_en_sl_i, clk_en_pl_i;
    logic        arst_e_core_ni, arst_p_core_ni, arst_cl_ni, arst_sl_ni, arst_pl_ni;
    logic        clk_e_core_o, clk_p_core_o, clk_cl_o, clk_sl_o, clk_pl_o;
    logic        arst_e_core_no, arst_p_core_no, arst_cl_no, arst_sl_no, arst_pl_no;
    logic        clk_src_cl_o;

    clk_rst_generator dut (
        .ref_clk_i            (ref_clk_i),
        .glob_arst_i          (glob_arst_i),
        .rtc_o                (rtc_o),
        .pll_ref_div_e_core_i (pll_ref_div_e_core_i),
        .pll_fb_div_e_core_i  (pll_fb_div_e_core_i),
        .pll_locked_e_core_o  (pll_locked_e_core_o),
        .pll_ref_div_p_core_i (pll_ref_div_p_core_i),
        .pll_fb_div_p_core_i  (pll_fb_div_p_core_i),
        .pll_locked_p_core_o  (pll_locked_p_core_o),
        .pll_ref_div_sl_i     (pll_ref_div_sl_i),
        .pll_fb_div_sl_i      (pll_fb_div_sl_i),
        .pll_locked_sl_o      (pll_locked_sl_o),
        .clk_en_e_core_i      (clk_en_e_core_i),
        .clk_en_p_core_i      (clk_en_p_core_i),
        .clk_en_cl_i          (clk_en_cl_i),
        .clk_en_sl_i          (clk_en_sl_i),
        .clk_en_pl_i          (clk_en_pl_i),
        .arst_e_core_ni       (arst_e_core_ni),
        .arst_p_core_ni       (arst_p_core_ni),
        .arst_cl_ni           (arst_cl_ni),
        .arst_sl_ni           (arst_sl_ni),
        .arst_pl_ni           (arst_pl_ni),
        .clk_e_core_o         (clk_e_core_o),
        .clk_p_core_o         (clk_p_core_o),
        .clk_cl_o             (clk_cl_o),
        .clk_sl_o             (clk_sl_o),
        .clk_pl_o             (clk_pl_o),
        .arst_e_core_no       (arst_e_core_no),
        .arst_p_core_no       (arst_p_core_no),
        .arst_cl_no           (arst_cl_no),
        .arst_sl_no           (arst_sl_no),
        .arst_pl_no           (arst_pl_no),
        .clk_src_cl_o         (clk_src_cl_o)
    );

    always #5 ref_clk_i = ~ref_clk_i;

    // Observed vector: {locked sl,pc,e | arst_n pl,sl,cl,pc,e | clk pl,sl,cl,pc,e | src_cl | rtc}
    localparam logic [14:0] M_LOCK = 15'h7000;
    localparam logic [14:0] M_ARST = 15'h0F80;
    localparam logic [14:0] M_CLK  = 15'h007C;
    localparam logic [14:0] M_SRC  = 15'h0002;
    localparam logic [14:0] M_RTC  = 15'h0001;
    localparam logic [14:0] M_ALL  = 15'h7FFF;

    logic [14:0] obs;
    assign obs = {pll_locked_sl_o, pll_locked_p_core_o, pll_locked_e_core_o,
                  arst_pl_no, arst_sl_no, arst_cl_no, arst_p_core_no, arst_e_core_no,
                  clk_pl_o, clk_sl_o, clk_cl_o, clk_p_core_o, clk_e_core_o,
                  clk_src_cl_o, rtc_o};

    typedef struct {
        time         t;
        string       name;
        logic [14:0] mask;
        logic [14:0] val;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_rel  = 0;

    always @(posedge ref_clk_i) n_rel <= glob_arst_i ? 0 : n_rel + 1;

    function automatic logic [14:0] mk(input logic [2:0] lk, input logic [4:0] ar,
                                       input logic [4:0] ck, input logic src, input logic rtc);
        return {lk, ar, ck, src, rtc};
    endfunction

    task automatic push(input time t, input string name, input logic [14:0] mask,
                        input logic [14:0] val);
        exp_t e;
        e.t = t; e.name = name; e.mask = mask; e.val = val;
        q.push_back(e);
    endtask

    // Sample time just after the j-th rising edge, when called 2 units past a falling edge.
    function automatic time ta(input int j);
        return $time - 6 + 10 * j;
    endfunction

    task automatic at_low(input int n);
        repeat (n) @(negedge ref_clk_i);
        #2;
    endtask

    task automatic at_high();
        @(posedge ref_clk_i);
        #2;
    endtask

    initial begin : monitor
        int i;
        forever begin
            #1;
            i = 0;
            while (i < q.size()) begin
                if (q[i].t <= $time) begin
                    n_vec++;
                    if ((obs & q[i].mask) !== (q[i].val & q[i].mask)) begin
                        n_miss++;
                        $display("FAIL %s @%0t: got %b, want %b (mask %b)",
                                 q[i].name, $time, obs & q[i].mask, q[i].val & q[i].mask, q[i].mask);
                    end
                    q.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    initial begin : stimulus
        time h;
        int  e, d;
        logic v1;

        glob_arst_i = 1'b1;
        pll_ref_div_e_core_i = 4'd4;  pll_fb_div_e_core_i = 12'd48;
        pll_ref_div_p_core_i = 4'd4;  pll_fb_div_p_core_i = 12'd48;
        pll_ref_div_sl_i     = 4'd4;  pll_fb_div_sl_i     = 12'd48;
        {clk_en_e_core_i, clk_en_p_core_i, clk_en_cl_i, clk_en_sl_i, clk_en_pl_i} = 5'b11111;
        {arst_e_core_ni, arst_p_core_ni, arst_cl_ni, arst_sl_ni, arst_pl_ni}      = 5'b11111;

        // 1: reset values, source clock free-running
        push(6,  "rst_high",      M_ALL, mk(3'b000, 5'b00000, 5'b00000, 1'b1, 1'b0));
        push(11, "rst_low",       M_ALL, mk(3'b000, 5'b00000, 5'b00000, 1'b0, 1'b0));
        push(96, "rst_high_late", M_ALL, mk(3'b000, 5'b00000, 5'b00000, 1'b1, 1'b0));
        at_low(10);

        // 2: release -> lock after 64 edges, resets 2 edges later
        glob_arst_i = 1'b0;
        push(ta(63),     "lock_edge63",  M_LOCK | M_ARST | M_CLK, mk(3'b000, 5'b00000, 5'b00000, 1'b0, 1'b0));
        push(ta(64),     "lock_edge64",  M_LOCK | M_ARST,         mk(3'b111, 5'b00000, 5'b00000, 1'b0, 1'b0));
        push(ta(65),     "sync_edge65",  M_LOCK | M_ARST | M_CLK, mk(3'b111, 5'b00000, 5'b11111, 1'b0, 1'b0));
        push(ta(66),     "sync_edge66",  M_LOCK | M_ARST | M_CLK | M_SRC, mk(3'b111, 5'b11111, 5'b11111, 1'b1, 1'b0));
        push(ta(66) + 5, "clk_low_phase", M_CLK | M_SRC,         mk(3'b000, 5'b00000, 5'b00000, 1'b0, 1'b0));
        at_low(70);

        // 3: p_core feedback change while locked
        pll_fb_div_p_core_i = 12'd50;
        push(ta(1),  "pc_unlock",     M_LOCK | M_ARST,         mk(3'b101, 5'b11001, 5'b00000, 1'b0, 1'b0));
        push(ta(2),  "pc_gated",      M_LOCK | M_ARST | M_CLK, mk(3'b101, 5'b11001, 5'b11001, 1'b0, 1'b0));
        push(ta(63), "pc_relock_63",  M_LOCK | M_ARST,         mk(3'b101, 5'b11001, 5'b00000, 1'b0, 1'b0));
        push(ta(64), "pc_relock_64",  M_LOCK | M_ARST,         mk(3'b111, 5'b11001, 5'b00000, 1'b0, 1'b0));
        push(ta(66), "pc_rst_done",   M_LOCK | M_ARST | M_CLK, mk(3'b111, 5'b11111, 5'b11111, 1'b0, 1'b0));
        at_low(70);

        // 4: disable/enable cl clock in the high phase
        at_high();
        h = $time;
        clk_en_cl_i = 1'b0;
        push(h + 1,  "cl_dis_hold",  M_ARST | M_CLK | M_SRC, mk(3'b000, 5'b11111, 5'b11111, 1'b1, 1'b0));
        push(h + 9,  "cl_dis_gated", M_CLK | M_SRC,          mk(3'b000, 5'b00000, 5'b11011, 1'b1, 1'b0));
        push(h + 14, "cl_dis_low",   M_CLK | M_SRC,          mk(3'b000, 5'b00000, 5'b00000, 1'b0, 1'b0));
        push(h + 19, "cl_dis_held",  M_CLK | M_SRC,          mk(3'b000, 5'b00000, 5'b11011, 1'b1, 1'b0));
        at_low(2);
        at_high();
        h = $time;
        clk_en_cl_i = 1'b1;
        push(h + 1,  "cl_en_no_runt",   M_CLK | M_SRC, mk(3'b000, 5'b00000, 5'b11011, 1'b1, 1'b0));
        push(h + 9,  "cl_en_resume",    M_CLK | M_SRC, mk(3'b000, 5'b00000, 5'b11111, 1'b1, 1'b0));
        push(h + 12, "cl_en_full_high", M_CLK | M_SRC, mk(3'b000, 5'b00000, 5'b11111, 1'b1, 1'b0));
        at_low(3);

        // 5: pl domain reset request
        arst_pl_ni = 1'b0;
        push($time + 1, "pl_req_async", M_LOCK | M_ARST, mk(3'b111, 5'b01111, 5'b00000, 1'b0, 1'b0));
        push(ta(2),     "pl_req_held",  M_ARST,          mk(3'b000, 5'b01111, 5'b00000, 1'b0, 1'b0));
        at_low(3);
        arst_pl_ni = 1'b1;
        push(ta(1), "pl_rel_edge1", M_ARST, mk(3'b000, 5'b01111, 5'b00000, 1'b0, 1'b0));
        push(ta(2), "pl_rel_edge2", M_ARST, mk(3'b000, 5'b11111, 5'b00000, 1'b0, 1'b0));
        at_low(5);

        // 6: invalid sl config, plus rtc period
        pll_fb_div_sl_i = 12'd0;
        push(ta(1),  "sl_invalid",      M_LOCK | M_ARST, mk(3'b011, 5'b00111, 5'b00000, 1'b0, 1'b0));
        push(ta(2),  "sl_invalid_clk",  M_CLK,           mk(3'b000, 5'b00000, 5'b00111, 1'b0, 1'b0));
        push(ta(70), "sl_never_locks",  M_LOCK | M_ARST, mk(3'b011, 5'b00111, 5'b00000, 1'b0, 1'b0));
`ifdef CLK_RST_RTC_EN
        e  = (n_rel / 16 + 2) * 16;
        d  = e - n_rel;
        v1 = 1'((e / 16) % 2);
        push(ta(d - 1),  "rtc_before_toggle", M_RTC, {14'd0, ~v1});
        push(ta(d),      "rtc_toggle",        M_RTC, {14'd0, v1});
        push(ta(d + 15), "rtc_hold",          M_RTC, {14'd0, v1});
        push(ta(d + 16), "rtc_toggle_next",   M_RTC, {14'd0, ~v1});
`else
        e  = 0;
        d  = 0;
        v1 = 1'b0;
        push(ta(5),  "rtc_tied_a", M_RTC, {14'd0, v1});
        push(ta(21), "rtc_tied_b", M_RTC, {14'd0, v1});
`endif
        at_low(80);

        // 7: global reset mid-operation, then full relock
        pll_fb_div_sl_i = 12'd48;
        glob_arst_i = 1'b1;
        push($time + 1, "grst_async",   M_LOCK | M_ARST | M_CLK | M_RTC, mk(3'b000, 5'b00000, 5'b00000, 1'b0, 1'b0));
        push($time + 4, "grst_clk_off", M_CLK | M_SRC,                   mk(3'b000, 5'b00000, 5'b00000, 1'b1, 1'b0));
        at_low(3);
        glob_arst_i = 1'b0;
        push(ta(63), "grst_relock_63", M_LOCK,                  mk(3'b000, 5'b00000, 5'b00000, 1'b0, 1'b0));
        push(ta(64), "grst_relock_64", M_LOCK,                  mk(3'b111, 5'b00000, 5'b00000, 1'b0, 1'b0));
        push(ta(66), "grst_all_up",    M_LOCK | M_ARST | M_CLK, mk(3'b111, 5'b11111, 5'b11111, 1'b0, 1'b0));
        at_low(70);

        for (int k = 0; k < 100 && q.size() > 0; k++) @(posedge ref_clk_i);
        if (q.size() > 0) begin
            $display("FAIL drain: %0d expectations still pending, want 0", q.size());
            n_miss += q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
